// File: rtl/cpu1_div_pkg.sv
// rtl/cpu1_div_pkg.sv - shared types, constants and sign helpers for the CPU1 divider
package cpu1_div_pkg;

  localparam int DIV_WIDTH = 32;

  // Helpers work on a wide container; callers size-cast in and out, so WIDTH must not exceed this.
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } div_state_t;

  function automatic logic [MAX_WIDTH-1:0] negate(input logic [MAX_WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] v,
                                                   input logic is_neg);
    return is_neg ? negate(v) : v;
  endfunction

endpackage

// File: rtl/cpu1_div_step.sv
// rtl/cpu1_div_step.sv - one combinational radix-2 restoring division step
module cpu1_div_step
  import cpu1_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // quo holds the unconsumed dividend bits on top and the quotient bits grown from the bottom.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/cpu1_div_cell.sv
// rtl/cpu1_div_cell.sv - iterative signed/unsigned restoring divider, WIDTH+2 cycle latency
module cpu1_div_cell
  import cpu1_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_abort,
  output logic             div_ready,
  output logic             div_result_valid,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] src1_abs;
  logic [WIDTH-1:0] src2_abs;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             neg_q;
  logic             neg_r;
  logic             zero;
  logic             load;
  logic             finish;

  assign div_ready = (state == IDLE);
  assign load      = (state == IDLE) && div_start && !div_abort;
  assign finish    = (state == FIX) && !div_abort;

  always_comb begin
    src1_abs = WIDTH'(abs_val(MAX_WIDTH'(div_src1), div_signed & div_src1[WIDTH-1]));
    src2_abs = WIDTH'(abs_val(MAX_WIDTH'(div_src2), div_signed & div_src2[WIDTH-1]));
    quo_fix  = WIDTH'(abs_val(MAX_WIDTH'(quo), neg_q));
    rem_fix  = WIDTH'(abs_val(MAX_WIDTH'(rem), neg_r));
  end

  cpu1_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_next(rem_step),
    .quo_next(quo_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = DIV;
        end
      end
      DIV: begin
        if (div_abort) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt              <= '0;
      rem              <= '0;
      quo              <= '0;
      divisor          <= '0;
      neg_q            <= 1'b0;
      neg_r            <= 1'b0;
      zero             <= 1'b0;
      div_result_valid <= 1'b0;
      div_quotient     <= '0;
      div_remainder    <= '0;
      div_by_zero      <= 1'b0;
    end else begin
      div_result_valid <= 1'b0;
      if (load) begin
        rem     <= '0;
        quo     <= src1_abs;
        divisor <= src2_abs;
        neg_q   <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
        neg_r   <= div_signed & div_src1[WIDTH-1];
        zero    <= (div_src2 == '0);
        cnt     <= CNT_W'(WIDTH - 1);
      end else if (state == DIV) begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt - 1'b1;
      end
      // A zero divisor leaves |src1| in rem, so restoring its sign returns src1 unchanged.
      if (finish) begin
        div_quotient     <= zero ? '1 : quo_fix;
        div_remainder    <= rem_fix;
        div_by_zero      <= zero;
        div_result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu1_div_cell.sv
// tb/tb_cpu1_div_cell.sv - scoreboard bench for cpu1_div_cell with directed vectors
module tb_cpu1_div_cell;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_start;
  logic         div_signed;
  logic [W-1:0] div_src1;
  logic [W-1:0] div_src2;
  logic         div_abort;
  logic         div_ready;
  logic         div_result_valid;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu1_div_cell #(
    .WIDTH(W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .div_start       (div_start),
    .div_signed      (div_signed),
    .div_src1        (div_src1),
    .div_src2        (div_src2),
    .div_abort       (div_abort),
    .div_ready       (div_ready),
    .div_result_valid(div_result_valid),
    .div_quotient    (div_quotient),
    .div_remainder   (div_remainder),
    .div_by_zero     (div_by_zero)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic expect_it, input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic z);
    div_start  = 1'b1;
    div_signed = s;
    div_src1   = a;
    div_src2   = b;
    if (expect_it) sb.push_back('{q, r, z, cyc + LAT});
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_pending", W'(sb.size()), '0);
    sb.delete();
  endtask

  task automatic run(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    drive(s, a, b, 1'b1, q, r, z);
    tick();
    div_start = 1'b0;
    wait_done();
  endtask

  always @(negedge clk) begin
    if (div_result_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid=1 want no result (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", div_quotient, mon_e.q);
        chk("remainder", div_remainder, mon_e.r);
        chk("by_zero", W'(div_by_zero), W'(mon_e.z));
        chk("latency_cycle", W'(cyc), W'(mon_e.due));
        chk("ready_at_valid", W'(div_ready), W'(1));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_src1   = '0;
    div_src2   = '0;
    div_abort  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", W'(div_ready), W'(1));
    chk("rst_valid", W'(div_result_valid), '0);
    chk("rst_quotient", div_quotient, '0);
    chk("rst_remainder", div_remainder, '0);
    chk("rst_by_zero", W'(div_by_zero), '0);
    reset = 1'b0;
    tick();

    // 100/7 with busy-ready check, then 50/5 started in the valid cycle
    drive(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    tick();
    div_start = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk("busy_ready", W'(div_ready), '0);
      tick();
    end
    chk("ready_in_valid_cycle", W'(div_ready), W'(1));
    drive(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0);
    tick();
    div_start = 1'b0;
    wait_done();

    run(1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run(1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // start while busy is ignored
    drive(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    tick();
    div_start = 1'b0;
    repeat (9) tick();
    drive(1'b0, 32'd50, 32'd5, 1'b0, '0, '0, 1'b0);
    tick();
    div_start = 1'b0;
    wait_done();
    repeat (40) tick();

    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // abort mid-divide keeps held outputs and never pulses valid
    drive(1'b0, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0);
    tick();
    div_start = 1'b0;
    repeat (11) tick();
    div_abort = 1'b1;
    tick();
    div_abort = 1'b0;
    chk("abort_ready", W'(div_ready), W'(1));
    chk("abort_held_q", div_quotient, 32'd3);
    chk("abort_held_r", div_remainder, 32'd0);
    chk("abort_held_z", W'(div_by_zero), '0);
    repeat (40) tick();

    // abort together with start in IDLE drops the start
    drive(1'b0, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0);
    div_abort = 1'b1;
    tick();
    div_start = 1'b0;
    div_abort = 1'b0;
    chk("abort_start_dropped", W'(div_ready), W'(1));
    repeat (40) tick();

    // reset mid-divide
    drive(1'b0, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0);
    tick();
    div_start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    #1;
    chk("midrst_quotient", div_quotient, '0);
    chk("midrst_remainder", div_remainder, '0);
    chk("midrst_by_zero", W'(div_by_zero), '0);
    chk("midrst_ready", W'(div_ready), W'(1));
    chk("midrst_valid", W'(div_result_valid), '0);
    tick();
    reset = 1'b0;
    tick();
    run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu1_div_cell.md
Name: cpu1_div_cell

Overview:
Iterative radix-2 restoring divider for the CPU1 execute stage. It is the inverse-operation companion to the CPU1 multiply cell and services DIV/DIVU as a multi-cycle unit. It accepts dividend and divisor on a start handshake and returns quotient, remainder and a divide-by-zero flag after a fixed latency. Results stay held until the next accepted start.

Parameters:
WIDTH, 32, operand/result width in bits (≥4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
div_start  in  1  request; accepted only when div_ready=1
div_signed  in  1  1 = two's-complement DIV, 0 = unsigned DIVU; sampled with start
div_src1  in  WIDTH  dividend; sampled with start
div_src2  in  WIDTH  divisor; sampled with start
div_abort  in  1  pipeline flush; cancels an in-flight divide
div_ready  out  1  idle, can accept start
div_result_valid  out  1  one-cycle pulse, results valid
div_quotient  out  WIDTH  quotient, held until next accepted start
div_remainder  out  WIDTH  remainder, held until next accepted start
div_by_zero  out  1  divisor was zero, held with results

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. Reset forces the IDLE state, div_ready=1, div_result_valid=0, quotient/remainder=0 and div_by_zero=0.
- States: IDLE → DIV → FIX → IDLE.
- IDLE, start accepted in cycle 0 (div_start & div_ready):
  - Register abs(src1) and abs(src2). abs applies only if div_signed, otherwise the raw value is used.
  - Register neg_q = signed & (src1[MSB] ^ src2[MSB]) and neg_r = signed & src1[MSB].
  - Register zero = (src2 == 0).
  - Clear the partial remainder, load the iteration counter with WIDTH-1, and go to DIV.
- Ready/valid during a divide: div_ready=0 from cycle 1 until the valid pulse. div_result_valid drops on the cycle after the accepted start.
- DIV, one restoring step per cycle:
  - Shift {rem, quo} left by 1 with the dividend MSB entering rem.
  - trial = rem_shifted − divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem = trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - The counter decrements each step. After the step at count 0, go to FIX. DIV lasts exactly WIDTH cycles.
- FIX, one cycle:
  - quotient = neg_q ? −quo : quo; remainder = neg_r ? −rem : rem. Negation wraps modulo 2^WIDTH.
  - Division truncates toward zero, and the remainder takes the sign of the dividend.
  - Write all outputs, then go to IDLE.
- Result timing:
  - div_result_valid=1 and div_ready=1 in cycle WIDTH+2, so latency is WIDTH+2 cycles (34 at default).
  - A new start may be accepted in the same cycle as the valid pulse.
- Divide by zero:
  - Same latency, no special path.
  - Quotient = all ones. The raw restoring result gives this, and it is forced regardless of sign.
  - Remainder = src1 unmodified, div_by_zero=1.
- Signed overflow, most-negative / −1: quotient = most-negative (wrap), remainder = 0, div_by_zero=0.
- div_start while busy: ignored, with no effect on the in-flight divide.
- div_abort:
  - In DIV or FIX: go to IDLE next cycle, with no valid pulse and held outputs unchanged.
  - In IDLE: ignored. If asserted together with an accepted start, abort wins and the start is dropped.
- Reset mid-operation: immediate return to IDLE with the reset values above.

Decomposition:
- Package cpu1_div_pkg:
  - state enum {IDLE, DIV, FIX}
  - DIV_WIDTH default constant
  - counter width $clog2(WIDTH)
  - abs/negate helper functions
- Sub-module cpu1_div_step: one combinational restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - The top level keeps the FSM, counter, sign bookkeeping and output registers.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 → valid only in cycle 34; q=14, r=2, div_by_zero=0; div_ready=0 in cycles 1–33.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / −2 → q=0xFFFFFFFD, r=1.
- 0x80000000 / 0xFFFFFFFF: signed → q=0x80000000, r=0. Unsigned → q=0, r=0x80000000.
- 5 / 0: unsigned and signed each → q=0xFFFFFFFF, r=5, div_by_zero=1, valid at cycle 34. A following 9/3 start clears the flag (q=3, r=0).
- Back-to-back operations:
  - Start 100/7, pulse div_start with 50/5 at cycle 10 → second request ignored; only q=14 is returned.
  - Start 50/5 in the cycle-34 valid cycle → q=10, r=0 at cycle 68.
- Abort and reset mid-operation:
  - div_abort at cycle 12 → div_ready=1 at cycle 13; no valid pulse; outputs keep their prior values.
  - reset asserted at cycle 20 → outputs zero immediately.
  - A subsequent 100/7 completes normally.
